// File: rtl/cam_img_sequencer_if.sv
// Pixel stream handshake between the upstream source and the CAM sequencer.
// A beat transfers on any clock edge where pix_valid and pix_ready are both high.
interface cam_img_sequencer_if #(
   parameter int DATA_WIDTH = 24
);
   logic                  pix_valid;
   logic                  pix_ready;
   logic [DATA_WIDTH-1:0] pix_data;

   modport master (output pix_valid, pix_data, input pix_ready);
   modport slave  (input pix_valid, pix_data, output pix_ready);
endinterface

// File: rtl/cam_img_sequencer.sv
// Command sequencer for the CAM image-match array: streams load/query pixels into the
// array and folds the per-image match flags into a single hit/index result.
module cam_img_sequencer #(
   parameter int  ADDR_WIDTH = 15,
   parameter int  DATA_WIDTH = 24,
   parameter int  NO_OF_IMG  = 2,
   parameter int  DRAIN_CYC  = 4,
   localparam int SEL_W      = (NO_OF_IMG > 1) ? $clog2(NO_OF_IMG) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      img_sel,
   input  logic [ADDR_WIDTH-1:0] size,
   input  logic                  abort,
   cam_img_sequencer_if.slave    pix,
   output logic [NO_OF_IMG-1:0]  cam_we,
   output logic                  cam_match_en,
   output logic                  cam_clr,
   output logic [ADDR_WIDTH-1:0] cam_addr,
   output logic [DATA_WIDTH-1:0] cam_din,
   output logic [ADDR_WIDTH-1:0] cam_size,
   input  logic [NO_OF_IMG-1:0]  cam_match,
   output logic                  busy,
   output logic                  done,
   output logic                  hit,
   output logic [SEL_W-1:0]      hit_idx,
   output logic                  err
);

   typedef enum logic [2:0] {IDLE, LOAD, CLR, QSTREAM, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
   localparam logic [NO_OF_IMG-1:0]  W_ONE = 1;

   state_t                state;
   logic                  rdy;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [SEL_W-1:0]      sel_q;
   logic [3:0]            dcnt;
   logic [NO_OF_IMG-1:0]  acc;
   logic [NO_OF_IMG-1:0]  acc_nxt;
   logic                  xfer;
   logic                  last;

   assign pix.pix_ready = rdy;
   assign xfer          = pix.pix_valid & rdy;
   assign last          = (cnt == cam_size - A_ONE);
   assign acc_nxt       = acc | cam_match;

   function automatic logic [SEL_W-1:0] lowest(input logic [NO_OF_IMG-1:0] v);
      lowest = '0;
      for (int i = NO_OF_IMG - 1; i >= 0; i--)
         if (v[i]) lowest = SEL_W'(i);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rdy          <= 1'b0;
         cnt          <= '0;
         sel_q        <= '0;
         dcnt         <= '0;
         acc          <= '0;
         cam_we       <= '0;
         cam_match_en <= 1'b0;
         cam_clr      <= 1'b0;
         cam_addr     <= '0;
         cam_din      <= '0;
         cam_size     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         hit          <= 1'b0;
         hit_idx      <= '0;
         err          <= 1'b0;
      end else begin
         cam_we       <= '0;
         cam_match_en <= 1'b0;
         cam_clr      <= 1'b0;
         done         <= 1'b0;
         // abort wins over any beat presented in the same cycle
         if (abort && (state inside {LOAD, CLR, QSTREAM, DRAIN})) begin
            rdy   <= 1'b0;
            err   <= 1'b1;
            hit   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
         end else begin
            case (state)
               IDLE: if (start) begin
                  cam_size <= size;
                  sel_q    <= img_sel;
                  cnt      <= '0;
                  hit      <= 1'b0;
                  hit_idx  <= '0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  if (size == '0 || (!mode && int'(img_sel) >= NO_OF_IMG)) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (!mode) begin
                     rdy   <= 1'b1;
                     state <= LOAD;
                  end else begin
                     cam_clr <= 1'b1;
                     state   <= CLR;
                  end
               end
               LOAD, QSTREAM: if (xfer) begin
                  if (state == LOAD) cam_we <= W_ONE << sel_q;
                  else               cam_match_en <= 1'b1;
                  cam_addr <= cnt;
                  cam_din  <= pix.pix_data;
                  cnt      <= cnt + A_ONE;
                  if (last) begin
                     rdy <= 1'b0;
                     if (state == LOAD) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        dcnt  <= '0;
                        state <= DRAIN;
                     end
                  end
               end
               CLR: begin
                  acc   <= '0;
                  rdy   <= 1'b1;
                  state <= QSTREAM;
               end
               DRAIN: begin
                  acc  <= acc_nxt;
                  dcnt <= dcnt + 4'd1;
                  if (dcnt == 4'(DRAIN_CYC - 1)) begin
                     hit     <= |acc_nxt;
                     hit_idx <= lowest(acc_nxt);
                     done    <= 1'b1;
                     state   <= DONE;
                  end
               end
               DONE: begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cam_img_sequencer.sv
// Self-checking bench for cam_img_sequencer: array-side strobes are checked against a
// scoreboard of expected beats, command results are checked inline per scenario.
module tb_cam_img_sequencer;
   localparam int AW = 15, DW = 24, NI = 2, DC = 4, SW = 1;

   typedef struct {
      logic [NI-1:0] we;
      logic          me;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } exp_t;

   logic clk = 1'b0;
   logic reset, start, mode, abort;
   logic [SW-1:0] img_sel, hit_idx;
   logic [AW-1:0] size, cam_addr, cam_size;
   logic [NI-1:0] cam_we, cam_match;
   logic cam_match_en, cam_clr, busy, done, hit, err;
   logic [DW-1:0] cam_din;

   exp_t sb[$];
   int   nchk = 0, nfail = 0, clr_cnt = 0;

   cam_img_sequencer_if #(.DATA_WIDTH(DW)) pix();

   cam_img_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_IMG(NI), .DRAIN_CYC(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .img_sel(img_sel), .size(size),
      .abort(abort), .pix(pix), .cam_we(cam_we), .cam_match_en(cam_match_en),
      .cam_clr(cam_clr), .cam_addr(cam_addr), .cam_din(cam_din), .cam_size(cam_size),
      .cam_match(cam_match), .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
      .err(err)
   );

   always #5 clk = ~clk;

   // every array strobe must match the oldest expected beat
   always @(negedge clk) begin
      if (!reset) begin
         if (cam_clr) clr_cnt++;
         if (cam_we != '0 || cam_match_en) begin
            nchk++;
            if (sb.size() == 0) begin
               nfail++;
               $display("FAIL strobe_unexpected: we=%b match_en=%b addr=%0d required none",
                        cam_we, cam_match_en, cam_addr);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({cam_we, cam_match_en, cam_addr, cam_din} !== {e.we, e.me, e.addr, e.din}) begin
                  nfail++;
                  $display("FAIL beat: got we=%b me=%b addr=%0d din=%h, required we=%b me=%b addr=%0d din=%h",
                           cam_we, cam_match_en, cam_addr, cam_din, e.we, e.me, e.addr, e.din);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic m, input logic [SW-1:0] s, input logic [AW-1:0] n);
      start = 1'b1; mode = m; img_sel = s; size = n;
      tick();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [NI-1:0] we, input logic me,
                            input logic [AW-1:0] a);
      int k = 0;
      pix.pix_valid = 1'b1;
      pix.pix_data  = d;
      @(negedge clk);
      while (!pix.pix_ready && k < 50) begin
         k++;
         @(negedge clk);
      end
      nchk++;
      if (!pix.pix_ready) begin
         nfail++;
         $display("FAIL ready_timeout: pix_ready=0 after 50 cycles, required 1");
      end
      @(posedge clk);
      sb.push_back('{we, me, a, d});
      #1 pix.pix_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mode = 1'b0; img_sel = '0; size = '0; abort = 1'b0;
      cam_match = '0; pix.pix_valid = 1'b0; pix.pix_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nchk++;
      if ({busy, done, hit, err, hit_idx, pix.pix_ready, cam_we, cam_match_en, cam_clr} !== '0) begin
         nfail++;
         $display("FAIL reset_ctrl: busy=%b done=%b hit=%b err=%b rdy=%b we=%b required all 0",
                  busy, done, hit, err, pix.pix_ready, cam_we);
      end
      nchk++;
      if ({cam_addr, cam_size, cam_din} !== '0) begin
         nfail++;
         $display("FAIL reset_bus: addr=%0d size=%0d din=%h required 0", cam_addr, cam_size, cam_din);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_load();
      logic [DW-1:0] px[4] = '{24'hA0A0A0, 24'hB1B1B1, 24'hC2C2C2, 24'hD3D3D3};
      do_start(1'b0, 1'b1, 15'd4);
      @(negedge clk);
      nchk++;
      if ({pix.pix_ready, busy, cam_size} !== {1'b1, 1'b1, 15'd4}) begin
         nfail++;
         $display("FAIL load_entry: rdy=%b busy=%b size=%0d required 1 1 4", pix.pix_ready, busy, cam_size);
      end
      tick();
      for (int i = 0; i < 4; i++) send_beat(px[i], 2'b10, 1'b0, AW'(i));
      @(negedge clk);
      nchk++;
      if ({done, err, hit} !== 3'b100) begin
         nfail++;
         $display("FAIL load_done: done=%b err=%b hit=%b required 1 0 0", done, err, hit);
      end
      @(negedge clk);
      nchk++;
      if ({done, busy} !== 2'b00 || sb.size() != 0) begin
         nfail++;
         $display("FAIL load_end: done=%b busy=%b pending=%0d required 0 0 0", done, busy, sb.size());
      end
      tick();
   endtask

   task automatic test_query();
      logic [NI-1:0] mf[3] = '{2'b11, 2'b10, 2'b00};
      logic [NI-1:0] mr[3] = '{2'b11, 2'b00, 2'b00};
      logic          eh[3] = '{1'b1, 1'b1, 1'b0};
      logic [SW-1:0] ei[3] = '{1'b0, 1'b1, 1'b0};
      for (int p = 0; p < 3; p++) begin
         int k = 0;
         clr_cnt = 0;
         do_start(1'b1, 1'b0, 15'd4);
         @(negedge clk);
         nchk++;
         if ({cam_clr, pix.pix_ready, busy} !== 3'b101) begin
            nfail++;
            $display("FAIL query_clr[%0d]: clr=%b rdy=%b busy=%b required 1 0 1", p, cam_clr, pix.pix_ready, busy);
         end
         tick();
         for (int i = 0; i < 4; i++) send_beat(DW'(32'h5000 + i + p * 16), 2'b00, 1'b1, AW'(i));
         cam_match = mf[p];
         @(negedge clk);
         while (!done && k < 20) begin
            tick();
            k++;
            if (k == 1) cam_match = mr[p];
            @(negedge clk);
         end
         cam_match = '0;
         nchk++;
         if (k !== DC) begin
            nfail++;
            $display("FAIL drain_len[%0d]: done after %0d cycles, required %0d", p, k, DC);
         end
         nchk++;
         if ({hit, hit_idx, err} !== {eh[p], ei[p], 1'b0}) begin
            nfail++;
            $display("FAIL query_result[%0d]: hit=%b idx=%0d err=%b required %b %0d 0", p, hit, hit_idx, err, eh[p], ei[p]);
         end
         nchk++;
         if (clr_cnt !== 1) begin
            nfail++;
            $display("FAIL clr_count[%0d]: %0d pulses, required 1", p, clr_cnt);
         end
         tick();
      end
   endtask

   task automatic test_valid_gaps();
      logic vp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int idx = 0;
      do_start(1'b0, 1'b0, 15'd2);
      for (int i = 0; i < 4; i++) begin
         pix.pix_valid = vp[i];
         pix.pix_data  = DW'(32'h100 + i);
         @(posedge clk);
         if (vp[i]) begin
            sb.push_back('{2'b01, 1'b0, AW'(idx), DW'(32'h100 + i)});
            idx++;
         end
         #1;
      end
      pix.pix_valid = 1'b0;
      @(negedge clk);
      nchk++;
      if ({done, err} !== 2'b10) begin
         nfail++;
         $display("FAIL gaps_done: done=%b err=%b required 1 0", done, err);
      end
      tick();
   endtask

   task automatic test_size_zero();
      for (int m = 0; m < 2; m++) begin
         clr_cnt = 0;
         do_start(1'(m), 1'b0, 15'd0);
         @(negedge clk);
         nchk++;
         if ({done, err, busy, pix.pix_ready} !== 4'b1110) begin
            nfail++;
            $display("FAIL size0_done[%0d]: done=%b err=%b busy=%b rdy=%b required 1 1 1 0", m, done, err, busy, pix.pix_ready);
         end
         tick();
         @(negedge clk);
         nchk++;
         if ({done, err, busy} !== 3'b010 || clr_cnt !== 0) begin
            nfail++;
            $display("FAIL size0_end[%0d]: done=%b err=%b busy=%b clr=%0d required 0 1 0 0", m, done, err, busy, clr_cnt);
         end
         tick();
      end
   endtask

   task automatic test_abort();
      do_start(1'b1, 1'b0, 15'd5);
      tick();
      send_beat(24'h0A0001, 2'b00, 1'b1, 15'd0);
      send_beat(24'h0A0002, 2'b00, 1'b1, 15'd1);
      abort = 1'b1;
      pix.pix_valid = 1'b1;
      pix.pix_data  = 24'hDEAD00;
      tick();
      abort = 1'b0;
      @(negedge clk);
      nchk++;
      if ({done, err, hit, pix.pix_ready, cam_match_en} !== 5'b11000) begin
         nfail++;
         $display("FAIL abort_done: done=%b err=%b hit=%b rdy=%b me=%b required 1 1 0 0 0",
                  done, err, hit, pix.pix_ready, cam_match_en);
      end
      tick();
      repeat (3) tick();
      pix.pix_valid = 1'b0;
      @(negedge clk);
      nchk++;
      if ({busy, done, err} !== 3'b001 || sb.size() != 0) begin
         nfail++;
         $display("FAIL abort_end: busy=%b done=%b err=%b pending=%0d required 0 0 1 0", busy, done, err, sb.size());
      end
      tick();
   endtask

   task automatic test_reset_mid_load();
      do_start(1'b0, 1'b1, 15'd4);
      send_beat(24'h111111, 2'b10, 1'b0, 15'd0);
      send_beat(24'h222222, 2'b10, 1'b0, 15'd1);
      #2 reset = 1'b1;
      #1;
      nchk++;
      if ({busy, done, pix.pix_ready, cam_we, cam_addr, cam_din, cam_size} !== '0) begin
         nfail++;
         $display("FAIL reset_mid: busy=%b rdy=%b we=%b addr=%0d size=%0d required all 0",
                  busy, pix.pix_ready, cam_we, cam_addr, cam_size);
      end
      sb.delete();
      tick();
      reset = 1'b0;
      tick();
      @(negedge clk);
      nchk++;
      if ({busy, done} !== 2'b00) begin
         nfail++;
         $display("FAIL reset_no_done: busy=%b done=%b required 0 0", busy, done);
      end
      tick();
      do_start(1'b0, 1'b0, 15'd3);
      for (int i = 0; i < 3; i++) send_beat(DW'(32'h330000 + i), 2'b01, 1'b0, AW'(i));
      @(negedge clk);
      nchk++;
      if ({done, err, cam_size} !== {1'b1, 1'b0, 15'd3}) begin
         nfail++;
         $display("FAIL reload_done: done=%b err=%b size=%0d required 1 0 3", done, err, cam_size);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int k = 0;
      // start mid-load must not restart or resize the command
      do_start(1'b0, 1'b1, 15'd3);
      send_beat(24'h400000, 2'b10, 1'b0, 15'd0);
      start = 1'b1; mode = 1'b1; size = 15'd0;
      send_beat(24'h400001, 2'b10, 1'b0, 15'd1);
      start = 1'b0;
      send_beat(24'h400002, 2'b10, 1'b0, 15'd2);
      @(negedge clk);
      nchk++;
      if ({done, err, cam_size} !== {1'b1, 1'b0, 15'd3}) begin
         nfail++;
         $display("FAIL ignore_start: done=%b err=%b size=%0d required 1 0 3", done, err, cam_size);
      end
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      nchk++;
      if ({busy, done, err} !== 3'b000) begin
         nfail++;
         $display("FAIL idle_abort: busy=%b done=%b err=%b required 0 0 0", busy, done, err);
      end
      tick();
      do_start(1'b0, 1'b0, 15'd1);
      send_beat(24'h500000, 2'b01, 1'b0, 15'd0);
      @(negedge clk);
      nchk++;
      if ({done, err} !== 2'b10) begin
         nfail++;
         $display("FAIL size1_load: done=%b err=%b required 1 0", done, err);
      end
      tick();
      do_start(1'b1, 1'b0, 15'd1);
      tick();
      send_beat(24'h500000, 2'b00, 1'b1, 15'd0);
      cam_match = 2'b01;
      @(negedge clk);
      while (!done && k < 20) begin
         tick();
         k++;
         @(negedge clk);
      end
      cam_match = '0;
      nchk++;
      if ({done, hit, hit_idx, err} !== 4'b1100 || k !== DC) begin
         nfail++;
         $display("FAIL size1_query: done=%b hit=%b idx=%0d err=%b cycles=%0d required 1 1 0 0 %0d",
                  done, hit, hit_idx, err, k, DC);
      end
      tick();
      nchk++;
      if (sb.size() != 0) begin
         nfail++;
         $display("FAIL sb_drain: %0d beats never seen, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_query();
      test_valid_gaps();
      test_size_zero();
      test_abort();
      test_reset_mid_load();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
